// File: rtl/jk_mode_counter.sv
// jk_mode_counter
//   WIDTH-bit register of JK cells with four operating modes:
//   per-bit JK direct, modulo-MODULUS up count, modulo-MODULUS down count
//   and parallel load (clamped to MODULUS-1).
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous reset, active-high (Q <= 0, wrap <= 0)
//   en    : update enable; 0 holds Q (wrap still clears)
//   mode  : 00 JK direct, 01 count up, 10 count down, 11 parallel load
//   J, K  : per-bit JK inputs (mode 00)
//   d     : parallel load data (mode 11)
//   Q     : registered state
//   Qn    : bitwise complement of Q
//   tc    : terminal count, high in the cycle before a wrapping edge
//   wrap  : registered one-cycle pulse, count wrapped on the previous edge
module jk_mode_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Modulus held one bit wider so MODULUS == 2^WIDTH is representable.
    localparam logic [WIDTH:0]   C_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;
    mode_e            w_mode;

    assign w_mode  = mode_e'(mode);
    assign w_q_ext = {1'b0, r_q};
    assign w_d_ext = {1'b0, d};

    always_comb begin
        w_next      = r_q;
        w_wrap_next = 1'b0;
        unique case (w_mode)
            // Characteristic equation Q+ = J&~Q | ~K&Q covers hold/reset/set/toggle.
            MODE_JK: begin
                w_next = (J & ~r_q) | (~K & r_q);
            end
            MODE_UP: begin
                if (w_q_ext >= {1'b0, C_MAX}) begin
                    w_next      = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_next = WIDTH'(w_q_ext + 1'b1);
                end
            end
            MODE_DOWN: begin
                if (r_q == '0) begin
                    w_next      = C_MAX;
                    w_wrap_next = 1'b1;
                end else if (w_q_ext >= C_MOD) begin
                    // Out-of-range value left by JK direct: recover without a wrap pulse.
                    w_next = C_MAX;
                end else begin
                    w_next = WIDTH'(w_q_ext - 1'b1);
                end
            end
            MODE_LOAD: begin
                w_next = (w_d_ext < C_MOD) ? d : C_MAX;
            end
            default: begin
                w_next      = r_q;
                w_wrap_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (en) begin
            r_q    <= w_next;
            r_wrap <= w_wrap_next;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign Qn   = ~r_q;
    assign wrap = r_wrap;
    assign tc   = en & (((w_mode == MODE_UP)   && (r_q == C_MAX)) ||
                        ((w_mode == MODE_DOWN) && (r_q == '0)));

endmodule

// File: tb/tb_jk_mode_counter.sv
// tb_jk_mode_counter
//   Scoreboard bench for jk_mode_counter (WIDTH=4, MODULUS=10).
//   An integer reference model predicts Q/Qn/wrap per edge and tc per cycle.
module tb_jk_mode_counter;

    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 10;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic [W-1:0] d;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic         tc;
    logic         wrap;

    jk_mode_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .J    (J),
        .K    (K),
        .d    (d),
        .Q    (Q),
        .Qn   (Qn),
        .tc   (tc),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned q;
        int unsigned wrap;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned m_q      = 0;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] j, input logic [W-1:0] k,
                        input logic [W-1:0] dd, input string tag);
        exp_t        x;
        int unsigned exp_tc;
        int unsigned nq;
        int unsigned nw;
        @(negedge clk);
        rst  = r;
        en   = e;
        mode = m;
        J    = j;
        K    = k;
        d    = dd;
        #1;
        exp_tc = (e && ((m == 2'd1 && m_q == MOD - 1) || (m == 2'd2 && m_q == 0))) ? 1 : 0;
        check({tag, "_tc"}, tc, exp_tc);

        nq = m_q;
        nw = 0;
        if (r) begin
            nq = 0;
        end else if (e) begin
            case (m)
                2'd0: begin
                    nq = 0;
                    for (int i = 0; i < int'(W); i++) begin
                        int unsigned b;
                        b = (m_q >> i) & 1;
                        case ({j[i], k[i]})
                            2'b00: b = b;
                            2'b01: b = 0;
                            2'b10: b = 1;
                            2'b11: b = 1 - b;
                        endcase
                        nq = nq | (b << i);
                    end
                end
                2'd1: begin
                    if (m_q >= MOD - 1) begin nq = 0; nw = 1; end
                    else nq = m_q + 1;
                end
                2'd2: begin
                    if (m_q == 0) begin nq = MOD - 1; nw = 1; end
                    else if (m_q >= MOD) nq = MOD - 1;
                    else nq = m_q - 1;
                end
                default: nq = (int'(dd) < int'(MOD)) ? int'(dd) : MOD - 1;
            endcase
        end
        m_q    = nq;
        x.q    = nq;
        x.wrap = nw;
        sb.push_back(x);

        @(posedge clk);
        #1;
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check({tag, "_q"},    Q,    x.q);
            check({tag, "_qn"},   Qn,   (~x.q) & 32'hF);
            check({tag, "_wrap"}, wrap, x.wrap);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b01; J = '0; K = '0; d = '0;

        // Reset held for two edges while counting up is requested.
        step(1, 1, 2'b01, 0, 0, 0, "reset");
        step(1, 1, 2'b01, 0, 0, 0, "reset");
        check("reset_q_const",  Q,  4'h0);
        check("reset_qn_const", Qn, 4'hF);

        // Up count through the wrap: 1..9,0,1,2.
        for (int n = 0; n < 12; n++) step(0, 1, 2'b01, 0, 0, 0, "up");
        check("up_end_const", Q, 4'd2);

        // Down from 0 wraps to 9, then out-of-range recovery.
        step(1, 1, 2'b10, 0, 0, 0, "rst2");
        step(0, 1, 2'b10, 0, 0, 0, "down");
        check("down_wrap_const", wrap, 1);
        step(0, 1, 2'b10, 0, 0, 0, "down");
        step(0, 1, 2'b10, 0, 0, 0, "down");
        check("down_end_const", Q, 4'd7);
        step(0, 1, 2'b00, 4'hF, 4'h0, 0, "jkset");
        check("jkset_const", Q, 4'hF);
        step(0, 1, 2'b10, 0, 0, 0, "oor");
        check("oor_q_const",    Q,    4'd9);
        check("oor_wrap_const", wrap, 0);

        // JK direct truth table in one vector.
        step(0, 1, 2'b11, 0, 0, 4'b0101, "ld5");
        step(0, 1, 2'b00, 4'b1100, 4'b1010, 0, "jk1");
        check("jk1_const", Q, 4'b1101);
        step(0, 1, 2'b00, 4'b1100, 4'b1010, 0, "jk2");
        check("jk2_const", Q, 4'b0101);

        // Load and clamp, then wrap from the clamped value.
        step(0, 1, 2'b11, 0, 0, 4'd7, "ld7");
        check("ld7_const", Q, 4'd7);
        step(0, 1, 2'b11, 0, 0, 4'd13, "ld13");
        check("ld13_const", Q, 4'd9);
        step(0, 1, 2'b01, 0, 0, 0, "upwrap");
        check("upwrap_q_const",    Q,    4'd0);
        check("upwrap_wrap_const", wrap, 1);

        // Enable low holds; reset beats load.
        step(0, 1, 2'b11, 0, 0, 4'd5, "ld5b");
        for (int n = 0; n < 3; n++) step(0, 0, 2'b01, 0, 0, 0, "hold");
        check("hold_const", Q, 4'd5);
        step(1, 1, 2'b11, 0, 0, 4'd3, "rstprio");
        check("rstprio_const", Q, 4'd0);

        // Enable gates tc at the terminal value.
        step(0, 1, 2'b11, 0, 0, 4'd9, "ld9");
        step(0, 0, 2'b01, 0, 0, 0, "tcgate");

        // Random mix of all modes with occasional reset and enable drops.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                 4'($urandom), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jk_mode_counter.md
Name: jk_mode_counter

Overview:
- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit register of JK cells with four modes: per-bit JK direct, modulo-MODULUS up count, modulo-MODULUS down count, and parallel load.
- Used as the general counter/state register in the sequential-logic exercises; replaces hand-chained JK flip-flops.
- Single clock, rising-edge, synchronous active-high reset.

Parameters:
WIDTH, 4, register width in bits (1..16)
MODULUS, 10, count modulus; legal range 2..2^WIDTH; count sequence 0..MODULUS-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  update enable; 0 = hold all state (wrap still clears)
mode  input  2  00 JK direct, 01 count up, 10 count down, 11 parallel load
J  input  WIDTH  per-bit J inputs (mode 00 only)
K  input  WIDTH  per-bit K inputs (mode 00 only)
d  input  WIDTH  parallel load data (mode 11 only)
Q  output  WIDTH  registered state
Qn  output  WIDTH  bitwise complement of Q, combinational
tc  output  1  terminal count, combinational
wrap  output  1  registered one-cycle pulse: count wrapped on previous edge

Behaviour:
- Reset (rst=1 at rising edge): Q <= 0, wrap <= 0. Takes priority over en and mode. Qn = all ones, tc per rule below with Q=0.
- Reset mid-count: the next edge with rst=1 forces Q=0 regardless of mode. Counting resumes from 0 on the first edge with rst=0.
- en=0: Q holds. wrap <= 0.
- Mode 00 (JK direct), per bit i, next Q[i]:
  - J=0,K=0: hold
  - J=0,K=1: 0
  - J=1,K=0: 1
  - J=1,K=1: toggle
  - Result may exceed MODULUS-1. No clamping. wrap <= 0.
- Mode 01 (up):
  - Q >= MODULUS-1: Q <= 0, wrap <= 1.
  - Otherwise: Q <= Q+1, wrap <= 0.
- Mode 10 (down):
  - Q == 0: Q <= MODULUS-1, wrap <= 1.
  - Q >= MODULUS (out of range after JK/direct): Q <= MODULUS-1, wrap <= 0.
  - Otherwise: Q <= Q-1, wrap <= 0.
- Mode 11 (load):
  - d < MODULUS: Q <= d.
  - d >= MODULUS: Q <= MODULUS-1 (clamp).
  - wrap <= 0.
- tc = en & ((mode==01 & Q==MODULUS-1) | (mode==10 & Q==0)). tc is high exactly in the cycle before a wrapping edge; it is 0 in modes 00/11 and when en=0.
- Arithmetic: internal next-state computed at WIDTH+1 bits; no overflow beyond WIDTH. When MODULUS=2^WIDTH, the up wrap equals natural rollover.
- Latency: one clock from input to Q. Qn and tc follow Q combinationally.
- Mode change takes effect on the very next edge; no pipeline state other than Q and wrap.

Test Plan:
- Reset: WIDTH=4, MODULUS=10. Hold rst=1 for 2 edges with en=1, mode=01 -> Q=0, Qn=4'hF, wrap=0 after each edge.
- Up count wrap: rst=0, en=1, mode=01, 12 edges from Q=0 -> Q sequence 1..9,0,1,2. tc=1 only while Q=9. wrap=1 only in the cycle after Q goes 9->0.
- Down and out-of-range recovery:
  - mode=10 from Q=0 -> Q=9 with wrap=1, then 8, 7.
  - JK direct J=4'hF, K=0 -> Q=15.
  - Then mode=10 -> Q=9, wrap=0.
- JK direct: starting Q=4'b0101, J=4'b1100, K=4'b1010 -> Q=4'b1101. Repeat same inputs -> Q=4'b0101 (bit 3 toggles back, bit 1 reset, bit 2 set, bit 0 hold).
- Load and clamp:
  - mode=11, d=7 -> Q=7.
  - d=13 -> Q=9.
  - Then mode=01 -> Q=0 with wrap=1.
- Enable and reset priority:
  - en=0 for 3 edges at Q=5, mode=01 -> Q stays 5, tc=0, wrap=0.
  - rst=1 with en=1, mode=11, d=3 -> Q=0.
